// File: rtl/dac_channel_scheduler.sv
// Multi-channel DAC link scheduler: arbitrates NCH sample requesters and shifts one
// 32-bit command frame per grant over SPI. Define DAC_SCHED_FIXED_PRIO_EN for fixed priority.
//
// state | meaning
// IDLE  | link free, requests sampled, winner granted and latched
// SHIFT | dac_cs low, frame shifted MSB-first
// GAP   | dac_cs high for GAP_CYC cycles before next arbitration
module dac_channel_scheduler #(
    parameter int         NCH      = 4,
    parameter int         SCK_HALF = 2,
    parameter int         GAP_CYC  = 4,
    parameter logic [3:0] CMD      = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [12*NCH-1:0] sample,
    output logic [NCH-1:0]    grant,
    output logic              busy,
    output logic              frame_done,
    output logic              spi_mosi,
    output logic              spi_sck,
    output logic              dac_cs,
    output logic              dac_clr
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [HW-1:0] HALF_LD = HW'(SCK_HALF - 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [31:0]     frame;
    logic [4:0]      bit_cnt;
    logic [HW-1:0]   half_cnt;
    logic            phase_high;
    logic [GW-1:0]   gap_cnt;

    logic [3:0]      req_ext;
    logic [1:0]      win_idx;
    logic            win_vld;
    logic [11:0]     win_sample;
    logic [31:0]     win_frame;
    logic [4:0]      nxt_bit;

    assign req_ext = 4'(req);
    assign nxt_bit = bit_cnt - 5'd1;

    always_comb begin
        win_idx    = 2'd0;
        win_vld    = 1'b0;
        win_sample = 12'h000;
`ifdef DAC_SCHED_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            if (req_ext[i]) begin
                win_vld = 1'b1;
                win_idx = 2'(i);
            end
        end
`else
        // Rotating search starting at ptr, wrapping at NCH-1.
        for (int i = 0; i < NCH; i++) begin
            logic [2:0] cand;
            cand = 3'(ptr) + 3'(i);
            if (cand >= 3'(NCH)) cand = cand - 3'(NCH);
            if (!win_vld && req_ext[cand[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[1:0];
            end
        end
`endif
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == 2'(i)) win_sample = sample[12*i +: 12];
        end
        win_frame = {8'h00, CMD, 2'b00, win_idx, win_sample, 4'h0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            frame      <= 32'h0;
            bit_cnt    <= 5'd0;
            half_cnt   <= '0;
            phase_high <= 1'b0;
            gap_cnt    <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_sck    <= 1'b0;
            dac_cs     <= 1'b1;
            dac_clr    <= 1'b0;
        end else begin
            dac_clr    <= 1'b1;
            grant      <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant      <= NCH'(1) << win_idx;
                        frame      <= win_frame;
                        busy       <= 1'b1;
                        dac_cs     <= 1'b0;
                        spi_sck    <= 1'b0;
                        spi_mosi   <= win_frame[31];
                        bit_cnt    <= 5'd31;
                        half_cnt   <= HALF_LD;
                        phase_high <= 1'b0;
                        ptr        <= (win_idx == 2'(NCH - 1)) ? 2'd0 : win_idx + 2'd1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_cnt != '0) begin
                        half_cnt <= half_cnt - 1'b1;
                    end else begin
                        half_cnt <= HALF_LD;
                        if (!phase_high) begin
                            spi_sck    <= 1'b1;
                            phase_high <= 1'b1;
                        end else if (bit_cnt == 5'd0) begin
                            dac_cs     <= 1'b1;
                            spi_sck    <= 1'b0;
                            spi_mosi   <= 1'b0;
                            frame_done <= 1'b1;
                            gap_cnt    <= GAP_LD;
                            state      <= GAP;
                        end else begin
                            // mosi only moves on the falling sck edge
                            spi_sck    <= 1'b0;
                            phase_high <= 1'b0;
                            bit_cnt    <= nxt_bit;
                            spi_mosi   <= frame[nxt_bit];
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
